// File: rtl/sprite_pkg.sv
// Shared sprite constants and types: RGB word, screen size, colour key and per-image sprite sizes.
package sprite_pkg;

  localparam int RGB_W    = 12;
  typedef logic [RGB_W-1:0] rgb_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam rgb_t KEY_COLOR_DEF = 12'h0F0;

  localparam int HOLE_W   = 200;
  localparam int HOLE_H   = 150;
  localparam int MOLE_W   = 160;
  localparam int MOLE_H   = 120;
  localparam int HAMMER_W = 96;
  localparam int HAMMER_H = 96;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sprite_pipe_delay.sv
// N-stage shift register that keeps side-band pixel data aligned with the ROM read latency.
module sprite_pipe_delay #(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [N];
  logic [W-1:0] stage_d [N];

  // Next value of each stage: input feeds stage 0, every other stage takes its predecessor
  always_comb begin
    stage_d[0] = d_i;
    for (int i = 1; i < N; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        stage_q[i] <= {W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/sprite_fetch.sv
// Sprite ROM address generation, colour-key transparency and pixel output with a fixed 3-cycle latency.
// Optional horizontal flip enabled by defining SPRITE_FETCH_MIRROR_EN (adds the mirror input).
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned       SPR_W     = HOLE_W,
  parameter int unsigned       SPR_H     = HOLE_H,
  parameter int unsigned       ADDR_W    = 15,
  parameter int unsigned       DATA_W    = 12,
  parameter logic [DATA_W-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              de,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [9:0]        org_x,
  input  logic [9:0]        org_y,
  input  logic [RGB_W-1:0]  bg_rgb,
`ifdef SPRITE_FETCH_MIRROR_EN
  input  logic              mirror,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [RGB_W-1:0]  rgb_out,
  output logic              rgb_valid,
  output logic              hit_out
);

  localparam logic [9:0]        SPR_W_L  = 10'(SPR_W);
  localparam logic [9:0]        SPR_H_L  = 10'(SPR_H);
  localparam logic [7:0]        COL_LAST = 8'(SPR_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'((SPR_H - 1) * SPR_W);

  fetch_state_e      state_q, state_d;
  logic [9:0]        sx_q, sx_d, sy_q, sy_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              line_hit_q, line_hit_d, line_adv_q, line_adv_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [RGB_W-1:0]  rgb_out_q, rgb_out_d;
  logic              hit_out_q, hit_out_d, rgb_valid_q, rgb_valid_d;

  logic [9:0]        dx, dy;
  logic [7:0]        col, col_addr;
  logic              run_eff, hit0, line_hit_eff, line_adv_eff, opaque;
  logic [ADDR_W-1:0] base_eff;
  logic              dly_hit, dly_de;
  logic [RGB_W-1:0]  dly_bg;

  function automatic logic [ADDR_W-1:0] next_row(input logic [ADDR_W-1:0] base);
    if (base >= ROW_MAX) begin
      return base;
    end else begin
      return base + ROW_STEP;
    end
  endfunction

  // Frame FSM: runs from the first frame_start until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) state_d = ST_RUN;
        else             state_d = ST_IDLE;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 0: a frame_start pixel already sees the new origin, row_base 0 and fresh line flags
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (frame_start) begin
      sx_d = org_x;
      sy_d = org_y;
    end else begin
      sx_d = sx_q;
      sy_d = sy_q;
    end
    run_eff      = (state_q == ST_RUN) | frame_start;
    base_eff     = frame_start ? {ADDR_W{1'b0}} : row_base_q;
    line_hit_eff = frame_start ? 1'b0 : line_hit_q;
    line_adv_eff = frame_start ? 1'b0 : line_adv_q;
    dx   = pix_x - sx_d;
    dy   = pix_y - sy_d;
    col  = dx[7:0];
    hit0 = run_eff & de & (dx < SPR_W_L) & (dy < SPR_H_L);
  end

`ifdef SPRITE_FETCH_MIRROR_EN
  logic mirror_q, mirror_d;

  // Mirror flag is shadowed per frame like the origin
  always_comb begin
    if (frame_start) mirror_d = mirror;
    else             mirror_d = mirror_q;
  end

  // Mirror shadow register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mirror_q <= 1'b0;
    else        mirror_q <= mirror_d;
  end

  assign col_addr = mirror_d ? (COL_LAST - col) : col;
`else
  assign col_addr = col;
`endif

  // Row accumulator: step on the last column, or at line end if the box was clipped on the right
  always_comb begin
    row_base_d = base_eff;
    line_hit_d = line_hit_eff;
    line_adv_d = line_adv_eff;
    rom_addr_d = rom_addr_q;
    if (hit0) begin
      rom_addr_d = base_eff + ADDR_W'(col_addr);
      line_hit_d = 1'b1;
      if (col == COL_LAST) begin
        row_base_d = next_row(base_eff);
        line_adv_d = 1'b1;
      end else begin
        row_base_d = base_eff;
      end
    end else if (!de) begin
      if (line_hit_eff && !line_adv_eff) row_base_d = next_row(base_eff);
      else                               row_base_d = base_eff;
      line_hit_d = 1'b0;
      line_adv_d = 1'b0;
    end else begin
      rom_addr_d = rom_addr_q;
    end
  end

  sprite_pipe_delay #(
    .W (RGB_W + 2),
    .N (2)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({hit0, de, bg_rgb}),
    .q_o   ({dly_hit, dly_de, dly_bg})
  );

  // Output pixel: opaque texel, else background, blanked outside display enable
  always_comb begin
    opaque      = dly_hit & (rom_data != KEY_COLOR);
    hit_out_d   = opaque;
    rgb_valid_d = dly_de;
    if (!dly_de)     rgb_out_d = {RGB_W{1'b0}};
    else if (opaque) rgb_out_d = RGB_W'(rom_data);
    else             rgb_out_d = dly_bg;
  end

  // State, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sx_q        <= 10'd0;
      sy_q        <= 10'd0;
      row_base_q  <= {ADDR_W{1'b0}};
      line_hit_q  <= 1'b0;
      line_adv_q  <= 1'b0;
      rom_addr_q  <= {ADDR_W{1'b0}};
      rgb_out_q   <= {RGB_W{1'b0}};
      hit_out_q   <= 1'b0;
      rgb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      row_base_q  <= row_base_d;
      line_hit_q  <= line_hit_d;
      line_adv_q  <= line_adv_d;
      rom_addr_q  <= rom_addr_d;
      rgb_out_q   <= rgb_out_d;
      hit_out_q   <= hit_out_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rgb_out   = rgb_out_q;
  assign hit_out   = hit_out_q;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch: directed frames plus randomized scans against a geometric reference model.
`timescale 1ns/1ps
module tb_sprite_fetch;

  localparam int          W   = 200;
  localparam int          H   = 150;
  localparam logic [11:0] KEY = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        de = 1'b0;
  logic [9:0]  pix_x = 10'd0, pix_y = 10'd0, org_x = 10'd0, org_y = 10'd0;
  logic [11:0] bg_rgb = 12'd0;
  logic [11:0] rom_data = 12'd0;
  logic [14:0] rom_addr;
  logic [11:0] rgb_out;
  logic        rgb_valid, hit_out;

  int checks = 0;
  int errors = 0;

  // Reference model: shadow origin, run flag, expected address and expected output queue
  int  m_sx = 0, m_sy = 0, exp_addr = 0;
  bit  m_run = 1'b0;
  typedef struct {
    logic [11:0] rgb;
    logic        hit;
    logic        vld;
  } out_t;
  out_t exp_q[$];

  sprite_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .de          (de),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .org_x       (org_x),
    .org_y       (org_y),
    .bg_rgb      (bg_rgb),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rgb_out     (rgb_out),
    .rgb_valid   (rgb_valid),
    .hit_out     (hit_out)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input int a);
    if (a == 0) return 12'hABC;
    if (a % 11 == 3) return KEY;
    return 12'(a * 37 + 5);
  endfunction

  // Synchronous ROM model: data one clock after the address
  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    out_t z;
    z.rgb = 12'h000; z.hit = 1'b0; z.vld = 1'b0;
    m_run = 1'b0; m_sx = 0; m_sy = 0; exp_addr = 0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  // One pixel clock: drive at negedge, predict from geometry, check after the edge
  task automatic cyc(input bit fs, input bit d, input int x, input int y, input logic [11:0] bg);
    out_t e;
    int dx, dy;
    bit hit;
    logic [11:0] rd;
    frame_start = fs; de = d; pix_x = 10'(x); pix_y = 10'(y); bg_rgb = bg;
    if (fs) begin
      m_sx = int'(org_x); m_sy = int'(org_y); m_run = 1'b1;
    end
    dx = x - m_sx;
    dy = y - m_sy;
    hit = m_run && d && dx >= 0 && dx < W && dy >= 0 && dy < H;
    if (hit) exp_addr = dy * W + dx;
    rd = rom_fn(exp_addr);
    e.hit = hit && (rd != KEY);
    e.rgb = !d ? 12'h000 : (e.hit ? rd : bg);
    e.vld = d;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    frame_start = 1'b0;
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
    e = exp_q.pop_front();
    chk("rgb_out", 32'(rgb_out), 32'(e.rgb));
    chk("hit_out", 32'(hit_out), 32'(e.hit));
    chk("rgb_valid", 32'(rgb_valid), 32'(e.vld));
  endtask

  // Left-to-right scan of part of a line (always one in-box column), then a blanking cycle
  task automatic scan_line(input int y, input int nrand, input bit right);
    int xs[$];
    int hi_in, lo_r, hi_r;
    logic [11:0] bg;
    bg = 12'($urandom);
    hi_in = (m_sx + W - 1 > 639) ? 639 : m_sx + W - 1;
    lo_r  = (m_sx - 4 < 0) ? 0 : m_sx - 4;
    hi_r  = (m_sx + W + 3 > 639) ? 639 : m_sx + W + 3;
    xs.push_back($urandom_range(hi_in, m_sx));
    for (int i = 0; i < nrand; i++) xs.push_back($urandom_range(hi_r, lo_r));
    if (right && m_sx + W - 1 <= 639) xs.push_back(m_sx + W - 1);
    xs.sort();
    foreach (xs[i]) cyc(1'b0, 1'b1, xs[i], y, bg);
    cyc(1'b0, 1'b0, 0, y, bg);
  endtask

  initial begin
    int y_lo, y_hi;
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_rgb_out", 32'(rgb_out), 32'd0);
    chk("reset_hit_out", 32'(hit_out), 32'd0);
    chk("reset_rgb_valid", 32'(rgb_valid), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Idle before any frame_start: background only
    cyc(1'b0, 1'b1, 120, 60, 12'h456);
    cyc(1'b0, 1'b1, 130, 60, 12'h457);
    cyc(1'b0, 1'b0, 0, 60, 12'h000);

    // Frame 1 at (100,50): edges, key colour, full box scan with a mid-frame origin change
    org_x = 10'd100; org_y = 10'd50;
    cyc(1'b1, 1'b0, 0, 49, 12'h000);
    cyc(1'b0, 1'b1, 99, 50, 12'h321);
    cyc(1'b0, 1'b1, 100, 50, 12'h321);
    cyc(1'b0, 1'b1, 103, 50, 12'h123);
    cyc(1'b0, 1'b1, 299, 50, 12'h321);
    cyc(1'b0, 1'b1, 300, 50, 12'h321);
    cyc(1'b0, 1'b0, 0, 50, 12'h321);
    cyc(1'b0, 1'b1, 100, 51, 12'h222);
    cyc(1'b0, 1'b0, 0, 51, 12'h222);
    chk("row51_addr", 32'(rom_addr), 32'd200);
    for (int y = 52; y < 200; y++) begin
      if (y == 120) org_x = 10'd400;
      scan_line(y, 2, (y == 199) || ($urandom_range(3, 0) == 0));
    end
    chk("last_addr", 32'(rom_addr), 32'd29999);

    // Frame 2 at (400,50): frame_start coincides with the first visible pixel
    cyc(1'b1, 1'b1, 400, 50, 12'h0AA);
    chk("fs_de_addr", 32'(rom_addr), 32'd0);
    scan_line(50, 3, 1'b1);
    scan_line(51, 3, 1'b0);

    // Frame 3 at (540,50): box clipped at the right screen edge
    org_x = 10'd540;
    cyc(1'b1, 1'b0, 0, 49, 12'h000);
    scan_line(50, 3, 1'b0);
    cyc(1'b0, 1'b1, 540, 51, 12'h0BB);
    chk("clip_row51_addr", 32'(rom_addr), 32'd200);
    cyc(1'b0, 1'b1, 639, 51, 12'h0BB);
    cyc(1'b0, 1'b0, 0, 51, 12'h0BB);
    cyc(1'b0, 1'b1, 545, 52, 12'h0CC);
    cyc(1'b0, 1'b1, 546, 52, 12'h0CC);

    // Asynchronous reset mid-line
    #2 rst_n = 1'b0;
    #1;
    chk("async_rom_addr", 32'(rom_addr), 32'd0);
    chk("async_rgb_out", 32'(rgb_out), 32'd0);
    chk("async_hit_out", 32'(hit_out), 32'd0);
    chk("async_rgb_valid", 32'(rgb_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(1'b0, 1'b1, 560, 55, 12'h777);
    cyc(1'b0, 1'b1, 570, 55, 12'h778);
    cyc(1'b0, 1'b1, 580, 55, 12'h779);
    cyc(1'b0, 1'b0, 0, 55, 12'h000);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      org_x = 10'($urandom_range(639, 0));
      org_y = 10'($urandom_range(470, 0));
      cyc(1'b1, 1'b0, 0, 0, 12'h000);
      y_lo = (int'(org_y) > 0) ? int'(org_y) - 1 : 0;
      y_hi = (int'(org_y) + 5 > 479) ? 479 : int'(org_y) + 5;
      for (int y = y_lo; y <= y_hi; y++) begin
        scan_line(y, 3, $urandom_range(1, 0) == 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Pixel-pipeline stage directly upstream of the 12-bit sprite image ROMs (hole, mole, hammer images); one instance per sprite.
- Takes the current VGA scan position and the sprite origin, and generates the 15-bit ROM read address.
- Captures the 12-bit RGB word the ROM returns, applies colour-key transparency against a background colour, and emits a registered pixel to the VGA mixer.
- Fixed 3-cycle latency, aligned with a delayed display-enable.

Parameters:
- SPR_W, 200, sprite width in pixels (≤255).
- SPR_H, 150, sprite height in lines (SPR_W*SPR_H ≤ 2^ADDR_W).
- ADDR_W, 15, ROM address width.
- DATA_W, 12, ROM word / RGB width (4:4:4).
- KEY_COLOR, 12'h0F0, ROM value treated as transparent.

Ports:
- clk  in  1  pixel clock, same clock as the ROM.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse before the first visible pixel of a frame.
- de  in  1  display enable for pix_x/pix_y this cycle.
- pix_x  in  10  current column.
- pix_y  in  10  current line.
- org_x  in  10  sprite top-left column; sampled at frame_start.
- org_y  in  10  sprite top-left line; sampled at frame_start.
- bg_rgb  in  12  background colour for pixels outside the sprite or transparent; sampled with pix inputs.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  DATA_W  ROM output; valid one clk after rom_addr.
- rgb_out  out  12  registered output pixel.
- rgb_valid  out  1  de delayed by 3 cycles.
- hit_out  out  1  sprite covers this pixel with an opaque texel, aligned with rgb_out.

Behaviour:
- Reset (async assert, sync release):
  - rom_addr, rgb_out, rgb_valid and hit_out = 0.
  - Shadow origin = 0, row_base = 0.
  - FSM = IDLE.
- FSM:
  - IDLE → RUN on the first frame_start.
  - In IDLE every hit is 0, so the output is bg_rgb gated by de.
  - RUN persists until reset. Reset mid-frame returns to IDLE; no partial-frame addresses are issued.
- Origin shadowing: on frame_start, sx←org_x and sy←org_y. Origin changes mid-frame have no effect until the next frame.
- Stage 0 (cycle t):
  - hit0 = RUN & de & (pix_x−sx) < SPR_W & (pix_y−sy) < SPR_H. Use unsigned 10-bit subtraction, so negative differences wrap large and miss.
  - col = (pix_x−sx)[7:0].
- Address: rom_addr(t+1) = row_base + col when hit0; otherwise rom_addr holds its value (no toggling).
  - row_base is a registered accumulator, not a multiplier.
  - It increments by SPR_W on the hit at col == SPR_W−1.
  - It saturates at (SPR_H−1)*SPR_W.
  - It clears to 0 on frame_start.
- Boxes partially off-screen:
  - A line that enters the box but never reaches col SPR_W−1 must still advance row_base. Advance on the first de-low after any hit on that line (line-end detect) if col SPR_W−1 was not hit.
  - Addresses never exceed SPR_W*SPR_H−1.
- Pipeline: hit, de and bg_rgb are delayed alongside the address.
  - rom_data is valid at t+2.
  - rgb_out(t+3) = (hit & rom_data≠KEY_COLOR) ? rom_data : bg_rgb, forced to 0 when the delayed de = 0.
  - hit_out(t+3) = hit & rom_data≠KEY_COLOR.
  - rgb_valid(t+3) = de(t).
- Simultaneous frame_start and de: frame_start wins. The origin is updated first, and that pixel is evaluated against the new origin with row_base = 0.
- Throughput: one pixel per clk, no stalls, no backpressure.

Optional Feature:
- Macro SPRITE_FETCH_MIRROR_EN.
- When defined:
  - Adds input mirror (1 bit), sampled at frame_start.
  - When the sampled mirror = 1, the address becomes row_base + (SPR_W−1−col), giving a horizontal flip.
  - The line-end row_base advance keys on col == SPR_W−1 of the scan column, unchanged.
- When undefined: the port is absent and the address is always row_base + col.

Decomposition:
- Shared package sprite_pkg holds:
  - RGB_W=12 and the rgb_t typedef.
  - SCREEN_W=640, SCREEN_H=480.
  - Default KEY_COLOR.
  - Per-image SPR_W/SPR_H constants (hole, mole, hammer).
- One natural sub-module, sprite_pipe_delay: a parameterised N-stage shift register used for the hit/de/bg_rgb alignment.

Test Plan:
- Reset then frame_start with org=(100,50); scan pixel (100,50) with de=1 → rom_addr=0 at t+1; ROM model returns 12'hABC → rgb_out=12'hABC, hit_out=1, rgb_valid=1 at t+3.
- Scan (299,50) then (100,51) → rom_addr 199 then 200. Pixel (299,199) → rom_addr 29999. (300,50) and (99,50) → bg_rgb output, hit_out=0, rom_addr held.
- ROM returns KEY_COLOR 12'h0F0 inside the box with bg_rgb=12'h123 → rgb_out=12'h123, hit_out=0.
- org_x changed 100→400 mid-frame → no effect until the next frame_start. With org_x=540 (box clipped at 639), line 51 first address = 200.
- Assert rst_n low mid-line → all outputs 0 immediately. Pixels before the next frame_start → rgb_out=bg_rgb, hit_out=0.
- SPRITE_FETCH_MIRROR_EN, mirror=1, org=(0,0): pixel (0,0) → rom_addr 199; pixel (199,1) → rom_addr 200.
